// File: rtl/serial_deframer_if.sv
// rtl/serial_deframer_if.sv - serial input / parallel output bundle for serial_deframer
interface serial_deframer_if #(
  parameter int WIDTH = 8
);
  logic             din;
  logic             din_valid;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             parity_err;

  modport master (
    output din, din_valid,
    input  dout, dout_valid, busy, parity_err
  );

  modport slave (
    input  din, din_valid,
    output dout, dout_valid, busy, parity_err
  );
endinterface

// File: rtl/serial_deframer.sv
// rtl/serial_deframer.sv - start-bit framed MSB-first serial-to-parallel receiver
// Optional even-parity check compiled in with `define DEFRAMER_PARITY_EN.
module serial_deframer #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  serial_deframer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef DEFRAMER_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             parity_err_q, parity_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      parity_err_q <= parity_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    parity_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.din_valid && bus.din) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (bus.din_valid) begin
          shreg_d = {shreg_q[WIDTH-2:0], bus.din};
          // Counter stops at LAST so it never wraps.
          if (cnt_q == LAST) begin
`ifdef DEFRAMER_PARITY_EN
            state_d = PARITY;
`else
            dout_d       = {shreg_q[WIDTH-2:0], bus.din};
            dout_valid_d = 1'b1;
            state_d      = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef DEFRAMER_PARITY_EN
      PARITY: begin
        if (bus.din_valid) begin
          dout_d       = shreg_q;
          dout_valid_d = 1'b1;
          parity_err_d = bus.din ^ (^shreg_q);
          state_d      = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.parity_err = parity_err_q;

endmodule

// File: tb/tb_serial_deframer.sv
// tb/tb_serial_deframer.sv - scoreboard bench for serial_deframer (WIDTH=8)
module tb_serial_deframer;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic             perr;
    int               cyc;
  } exp_t;

  exp_t sb[$];

  serial_deframer_if #(.WIDTH(WIDTH)) bus ();

  serial_deframer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic d, input logic v);
    @(negedge clk);
    bus.din       = d;
    bus.din_valid = v;
  endtask

  // Sends start + data (+ parity) bits; optional invalid gap cycle after each bit.
  task automatic send_frame(input logic [WIDTH-1:0] word, input bit gap, input bit bad_par);
    logic bits[$];
    exp_t e;
    bits.push_back(1'b1);
    for (int i = WIDTH - 1; i >= 0; i--) bits.push_back(word[i]);
`ifdef DEFRAMER_PARITY_EN
    bits.push_back((^word) ^ bad_par);
`endif
    for (int i = 0; i < bits.size(); i++) begin
      if (i == 1) begin
        @(negedge clk);
        check("busy_in_frame", {31'd0, bus.busy}, 32'd1);
        bus.din       = bits[i];
        bus.din_valid = 1'b1;
      end else begin
        step(bits[i], 1'b1);
      end
      if (i == bits.size() - 1) begin
        e.word = word;
`ifdef DEFRAMER_PARITY_EN
        e.perr = bad_par;
`else
        e.perr = 1'b0;
`endif
        e.cyc  = cyc + 1;
        sb.push_back(e);
      end
      if (gap) step(1'($urandom), 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.dout_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("dout", {24'd0, bus.dout}, {24'd0, e.word});
          check("parity_err", {31'd0, bus.parity_err}, {31'd0, e.perr});
          check("strobe_cycle", cyc, e.cyc);
          check("busy_on_strobe", {31'd0, bus.busy}, 32'd0);
        end
      end else if (bus.parity_err) begin
        check("stray_parity_err", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    reset         = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_dout", {24'd0, bus.dout}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
    reset = 1'b0;

    // Idle hold with zeros
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      check("idle_dout", {24'd0, bus.dout}, 32'd0);
      check("idle_valid", {31'd0, bus.dout_valid}, 32'd0);
      check("idle_busy", {31'd0, bus.busy}, 32'd0);
    end

    send_frame(8'hA5, 1'b0, 1'b0);
    idle(4);

    send_frame(8'hA5, 1'b1, 1'b0);
    idle(4);

    // Partial frame then reset: discarded, no strobe
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    reset         = 1'b1;
    bus.din       = 1'b1;
    bus.din_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_dout", {24'd0, bus.dout}, 32'd0);
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(4);

    // Back-to-back: second start bit on the strobe cycle
    send_frame(8'h81, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b0, 1'b0);
    idle(4);

    send_frame(8'h00, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(4);

`ifdef DEFRAMER_PARITY_EN
    send_frame(8'hA5, 1'b0, 1'b0);
    idle(3);
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(3);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(3);
`endif

    idle(6);
    check("sb_drained", sb.size(), 32'd0);
    check("final_busy", {31'd0, bus.busy}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_deframer.md
# serial_deframer

Serial-to-parallel receiver that sits directly downstream of the `shift_reg` serial stage and consumes its one-bit `q` stream. It waits for a start bit, collects `WIDTH` data bits MSB-first, and can optionally check an even-parity bit. It then presents the assembled word with a one-cycle valid strobe to the parallel logic that follows.

## Interface
- `WIDTH`, default 8: number of data bits per frame, legal range 2..32.
- `clk`  input  1: rising-edge clock.
- `reset`  input  1: synchronous, active-high reset.
- `din`  input  1: serial data bit, driven by the upstream shift register output.
- `din_valid`  input  1: `din` is sampled only on edges where this is 1.
- `dout`  output  WIDTH: last completed word; holds until the next frame completes.
- `dout_valid`  output  1: one-cycle pulse, high when `dout` has just been updated.
- `busy`  output  1: high while a frame is in progress (any state other than IDLE).
- `parity_err`  output  1: one-cycle pulse coincident with `dout_valid` when the parity check fails; constant 0 unless parity is compiled in.

## Operation
- Reset state, applied on any edge with `reset`=1 (including mid-frame): state IDLE, bit counter 0, shift register 0, `dout`=0, `dout_valid`=0, `busy`=0, `parity_err`=0. A partial frame is discarded and produces no strobe.
- States: IDLE, DATA, and PARITY (PARITY exists only with `DEFRAMER_PARITY_EN`).
- IDLE:
  - `din_valid`=1 and `din`=1 is the start bit: go to DATA with counter=0.
  - `din`=0, or `din_valid`=0: stay in IDLE.
- DATA:
  - On each `din_valid`=1 edge: `shreg <= {shreg[WIDTH-2:0], din}` and counter+1. The first data bit ends up in the MSB.
  - On the edge that samples bit WIDTH-1 (counter = WIDTH-1):
    - Without parity: load `dout` with the assembled word, pulse `dout_valid`, return to IDLE.
    - With parity: go to PARITY.
- PARITY: on the next `din_valid`=1 edge, load `dout`, pulse `dout_valid`, and set `parity_err` = `din` XOR (XOR-reduce of the data word). Return to IDLE.
- `din_valid`=0 in DATA or PARITY: hold state, counter and shift register unchanged. There is no timeout.
- Counter width is `$clog2(WIDTH)`. The counter never wraps; it is cleared on entry to DATA.
- `busy` = (state != IDLE), registered.

## Timing
- All outputs are registered and update on the rising edge of `clk`.
- `dout`/`dout_valid` become visible in the cycle after the edge that samples the final frame bit: the last data bit without parity, the parity bit with it.
- Frame length is 1+WIDTH sampled bits, or 2+WIDTH with parity. With continuous `din_valid`, a frame occupies exactly that many cycles.
- `dout_valid` and `parity_err` are high for exactly one cycle per frame.
- Back-to-back frames: the state is IDLE during the `dout_valid` cycle, so a start bit sampled on that cycle's closing edge is accepted. There are no dead cycles between frames.
- `reset` has priority over every other input on the same edge.

## Configuration
- `DEFRAMER_PARITY_EN` defined:
  - PARITY state and parity bit are compiled in.
  - Even parity: a frame is good when its data ones plus the parity bit total an even number.
  - `parity_err` is driven as described under Operation.
  - On a parity error, `dout` is still updated and `dout_valid` still pulses.
- Not defined:
  - No PARITY state; a frame ends after the last data bit.
  - `parity_err` is tied to 0.

## Test plan
- Reset and idle hold (WIDTH=8): assert `reset` for 2 cycles, then drive `din`=0 with `din_valid`=1 for 10 cycles -> `dout`=0x00, `dout_valid`=0, `busy`=0 throughout.
- Single frame with continuous valid: start bit 1, then data 1,0,1,0,0,1,0,1 -> `busy`=1 from the cycle after the start edge; `dout`=0xA5 and `dout_valid`=1 for exactly one cycle after the 8th data edge; `busy`=0 in that same cycle.
- Gapped valid: the same frame with `din_valid` alternating 1/0 and `din` toggled randomly while `din_valid`=0 -> `dout`=0xA5; exactly one strobe, which arrives after the 9th valid edge.
- Reset mid-frame: start bit plus 4 data bits, then `reset` for 1 cycle, then a full frame carrying 0x3C -> no strobe before the reset; after the reset `dout`=0x00; then exactly one strobe with `dout`=0x3C.
- Back-to-back frames: 0x81 immediately followed by 0x7E, with the second start bit on the `dout_valid` cycle -> two strobes exactly 9 cycles apart, `dout`=0x81 then 0x7E.
- Parity (`DEFRAMER_PARITY_EN` defined): 0xA5 with parity bit 0 -> `dout_valid`=1, `parity_err`=0. 0xA5 with parity bit 1 -> `dout`=0xA5, `dout_valid`=1, `parity_err`=1 in the same cycle.
